// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types, widths and helpers for the systolic array feed path.
package systolic_pkg;
  localparam int DW = 8;
  localparam int SW = 17;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_CAPTURE, S_DONE} feed_state_t;
  function automatic logic [7:0] drain_last(input int drain);
    return 8'(drain - 1);
  endfunction
endpackage

// File: rtl/skew_line.sv
// skew_line: depth-D delay of {valid, data} measured from the read strobe; data lags its strobe by one cycle.
module skew_line #(
  parameter int D  = 1,
  parameter int DW = 8
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          vin,
  input  logic [DW-1:0] din,
  output logic          vout,
  output logic [DW-1:0] dout
);
  logic [D-1:0]  v;
  logic [DW-1:0] dq;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else v <= flush ? '0 : (v << 1) | D'(vin);
  // Buffer data already arrives one cycle after the strobe, so it needs one stage less than valid.
  if (D == 1) begin : g_direct
    assign dq = din;
  end else begin : g_pipe
    logic [DW-1:0] d [D-1];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) d <= '{default: '0};
      else if (flush) d <= '{default: '0};
      else begin
        for (int j = D - 2; j > 0; j--) d[j] <= d[j-1];
        d[0] <= din;
      end
    assign dq = d[D-2];
  end
  assign vout = v[D-1];
  assign dout = v[D-1] ? dq : '0;
endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: fetches K operand vectors, skews them onto the array edges and times result capture.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int KW    = 8,
  parameter int DW    = systolic_pkg::DW,
  parameter int DRAIN = 12
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            abort,
  output logic            busy,
  output logic            rd_en,
  output logic [KW-1:0]   rd_addr,
  input  logic [N*DW-1:0] rd_a,
  input  logic [N*DW-1:0] rd_b,
  output logic [N*DW-1:0] a_feed,
  output logic [N*DW-1:0] b_feed,
  output logic [N-1:0]    feed_vld,
  output logic            res_capture,
  output logic            done
);
  if (DRAIN < N || DRAIN > 255) begin : g_bad_drain
    $error("systolic_feed_ctrl: DRAIN must lie in N..255");
  end
  feed_state_t   state_q, state_d;
  logic [KW-1:0] k_q, addr_q;
  logic [7:0]    dcnt_q;
  logic [N-1:0]  a_vld, b_vld;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = (k_len == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (addr_q == k_q - KW'(1)) state_d = S_DRAIN;
      S_DRAIN:   if (dcnt_q == drain_last(DRAIN)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) k_q <= k_len;
      addr_q  <= (state_q == S_FETCH && state_d == S_FETCH) ? addr_q + KW'(1) : '0;
      dcnt_q  <= (state_q == S_DRAIN && state_d == S_DRAIN) ? dcnt_q + 8'd1 : '0;
    end
  assign busy        = state_q != S_IDLE;
  assign rd_en       = state_q == S_FETCH;
  assign rd_addr     = addr_q;
  assign res_capture = state_q == S_CAPTURE;
  assign done        = state_q == S_DONE;
  // Lane i sits i+1 cycles behind its strobe so operands meet on the array diagonal.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.D(i + 1), .DW(DW)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(abort), .vin(rd_en),
      .din(rd_a[i*DW +: DW]), .vout(a_vld[i]), .dout(a_feed[i*DW +: DW])
    );
    skew_line #(.D(i + 1), .DW(DW)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(abort), .vin(rd_en),
      .din(rd_b[i*DW +: DW]), .vout(b_vld[i]), .dout(b_feed[i*DW +: DW])
    );
  end
  assign feed_vld = a_vld & b_vld;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: directed vector table for one K=3 tile plus hand-written abort, reset and corner sequences.
module tb_systolic_feed_ctrl;
  localparam int N = 4, KW = 8, DW = 8, DRAIN = 12;
  logic            clk = 1'b0;
  logic            rst_n, start, abort;
  logic [KW-1:0]   k_len, rd_addr;
  logic            busy, rd_en, res_capture, done;
  logic [N*DW-1:0] rd_a, rd_b, a_feed, b_feed;
  logic [N-1:0]    feed_vld;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  systolic_feed_ctrl #(.N(N), .KW(KW), .DW(DW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
    .a_feed(a_feed), .b_feed(b_feed), .feed_vld(feed_vld),
    .res_capture(res_capture), .done(done)
  );
  // Operand buffer: A[k] lane i = 0x10*k+i, B[k] lane i = 0x80 | A[k] lane i; one-cycle read latency.
  always @(posedge clk)
    if (rd_en)
      for (int i = 0; i < N; i++) begin
        rd_a[i*DW +: DW] <= 8'(8'h10 * rd_addr + i);
        rd_b[i*DW +: DW] <= 8'(8'h80 | (8'h10 * rd_addr + i));
      end
  typedef struct {
    logic        rd_en;
    logic [7:0]  addr;
    logic [3:0]  vld;
    logic [31:0] a;
    logic        busy;
    logic        cap;
    logic        done;
  } vec_t;
  vec_t vec [18];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic wait_done(input int c0, output int cap_at, output int done_at, output int caps);
    cap_at = -1; done_at = -1; caps = 0;
    for (int c = c0; c < c0 + 200; c++) begin
      if (res_capture) begin cap_at = c; caps++; end
      if (done) begin done_at = c; return; end
      cyc();
    end
  endtask
  initial begin
    int cap_at, done_at, caps;
    logic [31:0] bexp;
    for (int c = 1; c <= 18; c++) vec[c-1] = '{1'b0, 8'h00, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    vec[0]  = '{1'b1, 8'h00, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 8'h01, 4'b0001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 8'h02, 4'b0011, 32'h00000110, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 8'h00, 4'b0111, 32'h00021120, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 8'h00, 4'b1110, 32'h03122100, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 8'h00, 4'b1100, 32'h13220000, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 8'h00, 4'b1000, 32'h23000000, 1'b1, 1'b0, 1'b0};
    vec[15] = '{1'b0, 8'h00, 4'b0000, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vec[16] = '{1'b0, 8'h00, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vec[17] = '{1'b0, 8'h00, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; k_len = '0;
    cyc(); cyc();
    chk("reset_outputs", {busy, rd_en, rd_addr, feed_vld, a_feed, res_capture, done}, '0);
    rst_n = 1'b1;
    cyc();
    // K=3 tile, table-driven per cycle
    start = 1'b1; k_len = 8'd3;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      bexp = vec[c-1].a;
      for (int i = 0; i < N; i++) if (vec[c-1].vld[i]) bexp[i*8 +: 8] = bexp[i*8 +: 8] | 8'h80;
      chk($sformatf("k3_rd_en_c%0d", c), 64'(rd_en), 64'(vec[c-1].rd_en));
      if (vec[c-1].rd_en) chk($sformatf("k3_addr_c%0d", c), 64'(rd_addr), 64'(vec[c-1].addr));
      chk($sformatf("k3_vld_c%0d", c), 64'(feed_vld), 64'(vec[c-1].vld));
      chk($sformatf("k3_afeed_c%0d", c), 64'(a_feed), 64'(vec[c-1].a));
      chk($sformatf("k3_bfeed_c%0d", c), 64'(b_feed), 64'(bexp));
      chk($sformatf("k3_busy_c%0d", c), 64'(busy), 64'(vec[c-1].busy));
      chk($sformatf("k3_cap_c%0d", c), 64'(res_capture), 64'(vec[c-1].cap));
      chk($sformatf("k3_done_c%0d", c), 64'(done), 64'(vec[c-1].done));
      cyc();
    end
    // K=0: straight to DONE, no reads, no capture
    start = 1'b1; k_len = 8'd0;
    cyc();
    start = 1'b0;
    chk("k0_c1_flags", {busy, done, rd_en, res_capture}, 4'b1100);
    cyc();
    chk("k0_c2_flags", {busy, done, rd_en, res_capture}, 4'b0000);
    // abort at cycle 6 of a K=8 tile, then restart at cycle 7
    start = 1'b1; k_len = 8'd8;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    chk("abort_pre_fetch", {busy, rd_en, rd_addr}, {1'b1, 1'b1, 8'd5});
    chk("abort_pre_vld", 64'(feed_vld), 64'hF);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_idle", {busy, rd_en, done, res_capture}, 4'b0000);
    chk("abort_vld", 64'(feed_vld), 64'h0);
    chk("abort_feeds", {a_feed, b_feed}, 64'h0);
    start = 1'b1; k_len = 8'd2;
    cyc();
    start = 1'b0;
    chk("restart_fetch", {busy, rd_en, rd_addr}, {1'b1, 1'b1, 8'd0});
    wait_done(1, cap_at, done_at, caps);
    chk("restart_cap_at", 64'(cap_at), 64'd15);
    chk("restart_done_at", 64'(done_at), 64'd16);
    chk("restart_caps", 64'(caps), 64'd1);
    cyc();
    chk("restart_idle", 64'(busy), 64'd0);
    // start during DRAIN is ignored
    start = 1'b1; k_len = 8'd2;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    start = 1'b1; k_len = 8'd5;
    cyc();
    start = 1'b0;
    wait_done(6, cap_at, done_at, caps);
    chk("drain_start_done_at", 64'(done_at), 64'd16);
    cyc();
    chk("drain_start_idle17", 64'(busy), 64'd0);
    cyc();
    chk("drain_start_idle18", {busy, rd_en}, 2'b00);
    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; k_len = 8'd4;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle1", {busy, rd_en}, 2'b00);
    cyc();
    chk("start_abort_idle2", {busy, rd_en, done}, 3'b000);
    // async reset mid-FETCH
    start = 1'b1; k_len = 8'd8;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    chk("rst_pre_fetch", {rd_en, rd_addr}, {1'b1, 8'd2});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {busy, rd_en, rd_addr, res_capture, done}, '0);
    chk("rst_async_feed", {feed_vld, a_feed, b_feed}, '0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_idle_after", {busy, rd_en, feed_vld}, '0);
    start = 1'b1; k_len = 8'd1;
    cyc();
    start = 1'b0;
    wait_done(1, cap_at, done_at, caps);
    chk("rst_rerun_done_at", 64'(done_at), 64'd15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for an N x N grid of `systolic_pe` tiles. It accepts a tile command and reads K operand vectors from the A/B operand buffers. It drives those vectors into the array's west (A) and north (B) edges with the diagonal skew the array needs, then waits out the pipeline drain. It signals when the edge `sum_out` values are ready to capture, and sits between the host command interface and the array's edge inputs.

## Interface
Parameters:
- `N`, 4: array dimension (lanes per edge).
- `KW`, 8: width of the K count and the buffer address.
- `DW`, 8: operand width per lane, matching the PE `a_in`/`b_in` width.
- `DRAIN`, 12: cycles from the last `rd_en` to `res_capture`. Legal range is N to 255; an elaboration-time check fails otherwise.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: tile request; accepted only in IDLE.
- `k_len` in KW: vector count K, sampled on accept.
- `abort` in 1: synchronous abort; returns to IDLE.
- `busy` out 1: high in every state except IDLE.
- `rd_en` out 1: operand buffer read strobe.
- `rd_addr` out KW: buffer address, 0..K-1.
- `rd_a` in N*DW: A column data; valid the cycle after `rd_en`.
- `rd_b` in N*DW: B row data; valid the cycle after `rd_en`.
- `a_feed` out N*DW: skewed A lanes to the array's west edge.
- `b_feed` out N*DW: skewed B lanes to the array's north edge.
- `feed_vld` out N: per-lane valid.
- `res_capture` out 1: 1-cycle pulse; array results are stable.
- `done` out 1: 1-cycle completion pulse.

## Operation
- FSM states are IDLE, FETCH, DRAIN, CAPTURE and DONE.
- IDLE:
  - `start` with `k_len` > 0 → FETCH; K is latched.
  - `start` with `k_len` = 0 → DONE. No reads are issued and no `res_capture` is asserted.
- FETCH:
  - `rd_en` = 1 every cycle; `rd_addr` counts 0..K-1.
  - After the K-th read → DRAIN.
- DRAIN: the counter runs DRAIN cycles, then → CAPTURE.
- CAPTURE: `res_capture` = 1 for one cycle, then → DONE.
- DONE: `done` = 1 for one cycle, then → IDLE.
- Skew:
  - Lane i (0..N-1) of `a_feed`/`b_feed` carries lane i of `rd_a`/`rd_b` delayed i+1 cycles after its `rd_en`.
  - `feed_vld[i]` follows the same delay.
  - Lanes with `feed_vld` = 0 drive zero.
- `start` while busy is ignored.
- `abort`:
  - Effective in any state; next cycle the FSM is IDLE, all skew registers are zero and `feed_vld` = 0.
  - No `res_capture` or `done` is produced.
  - `abort` and `start` in the same IDLE cycle: abort wins and the start is dropped.
- `rd_addr` never wraps; K = 2^KW - 1 is the maximum.
- Reset values: all outputs 0, FSM IDLE, counters 0, skew lines 0. Reset asserted mid-tile discards the tile.

## Timing
Start accepted in cycle 0, with F = cycle 1:
- FETCH occupies cycles 1..K.
- `rd_en` is high in cycles 1..K, with `rd_addr` = cycle-1.
- Lane i is valid in cycles 2+i..K+1+i.
- DRAIN occupies cycles K+1..K+DRAIN.
- `res_capture` at cycle K+DRAIN+1.
- `done` at K+DRAIN+2.
- IDLE (`busy` = 0) at K+DRAIN+3; a new `start` is accepted in that cycle.
- `busy` is high from cycle 1 through K+DRAIN+2.
- K = 0: DONE at cycle 1, IDLE at cycle 2.
- Throughput: one tile per K+DRAIN+3 cycles; there is no overlap between tiles.

## Structure
- Package `systolic_pkg` holds:
  - the FSM state enum;
  - `DW` default 8 and `SW` 17, the PE sum width;
  - the drain-length helper function.
- One sub-module, `skew_line`: a parameterised depth-D shift register of {valid, DW data} with async clear and a synchronous flush input driven by `abort`. It is instantiated 2N times, lane i at depth i+1.
- FSM and counters live in the top level.

## Test plan
- N=4, DRAIN=12, K=3, start at cycle 0:
  - `rd_addr` 0,1,2 in cycles 1-3.
  - Lane 0 valid cycles 2-4; lane 3 valid cycles 5-7.
  - `res_capture` at 16, `done` at 17, `busy` low at 18.
- Buffer words A[k] lane i = 0x10*k+i: at cycle 5 `a_feed` lane 3 = 0x03 and lane 0 = 0x00; lanes with `feed_vld` = 0 read zero.
- `k_len` = 0 → `done` at cycle 1, no `rd_en`, no `res_capture`.
- `abort` at cycle 6 of a K=8 tile → IDLE at 7, `feed_vld` = 0, no `done`. A new start at 7 is accepted and runs cleanly.
- `start` pulsed during DRAIN → ignored. `start`+`abort` in IDLE → stays IDLE.
- `rst_n` low for 1 cycle mid-FETCH → all outputs 0 immediately (asynchronously) and IDLE after release.
